// File: rtl/mem_ctrl_if.sv
// CPU-core memory port bundle: fetch, load and store requests plus their responses.
// Latency: none (signal grouping only). Backpressure: the responder raises stall and the core holds its requests.
interface mem_ctrl_if #(parameter int W = 32);
    logic [W-1:0] pc;
    logic [W-1:0] read_inst;
    logic         load_en;
    logic [W-1:0] l_addr;
    logic [W-1:0] l_data;
    logic         store_en;
    logic [W-1:0] s_addr;
    logic [W-1:0] s_data;
    logic         stall;

    modport master (
        output pc, load_en, l_addr, store_en, s_addr, s_data,
        input  read_inst, l_data, stall
    );

    modport slave (
        input  pc, load_en, l_addr, store_en, s_addr, s_data,
        output read_inst, l_data, stall
    );
endinterface

// File: rtl/mem_ctrl.sv
// Single-port RAM serving fetch/load/store, with a posted-store write buffer. MEM_CTRL_FWD_EN enables load forwarding.
// Latency: fetch and load data are registered, 1 cycle. Backpressure: stall=1 when a request is not served this cycle.
module mem_ctrl #(
    parameter int W        = 32,
    parameter int ADDR_W   = 10,
    parameter int WB_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    mem_ctrl_if.slave  bus
);
    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = $clog2(WB_DEPTH + 1);

    typedef logic [ADDR_W-1:0] idx_t;
    typedef enum logic [1:0] {GR_FETCH, GR_LOAD, GR_DRAIN} grant_t;

    logic [W-1:0]  ram [2**ADDR_W];
    idx_t          wb_idx [WB_DEPTH];
    logic [W-1:0]  wb_dat [WB_DEPTH];
    logic [PW-1:0] head, tail, pos;
    logic [CW-1:0] count;

    idx_t          pc_idx, l_idx, s_idx;
    logic          full, fwd_hit, push, drain;
    logic [W-1:0]  fwd_dat;
    grant_t        grant;
    logic          unused_addr_bits;

    assign pc_idx = bus.pc[ADDR_W+1:2];
    assign l_idx  = bus.l_addr[ADDR_W+1:2];
    assign s_idx  = bus.s_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{bus.pc[W-1:ADDR_W+2], bus.pc[1:0],
                                bus.l_addr[W-1:ADDR_W+2], bus.l_addr[1:0],
                                bus.s_addr[W-1:ADDR_W+2], bus.s_addr[1:0]};

    assign full = (count == CW'(WB_DEPTH));

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_hit = 1'b0;
        fwd_dat = '0;
        pos     = head;
        for (int i = 0; i < WB_DEPTH; i++) begin
            pos = head + PW'(i);
            if ((CW'(i) < count) && (wb_idx[pos] == l_idx)) begin
                fwd_hit = 1'b1;
                fwd_dat = wb_dat[pos];
            end
        end
    end

    always_comb begin
        grant = GR_FETCH;
        if (full) begin
            grant = GR_DRAIN;
        end
`ifdef MEM_CTRL_FWD_EN
        else if (bus.load_en) begin
            grant = GR_LOAD;
        end
`else
        // Without forwarding, a hazarding load drains the buffer until RAM is current.
        else if (bus.load_en && fwd_hit) begin
            grant = GR_DRAIN;
        end
        else if (bus.load_en) begin
            grant = GR_LOAD;
        end
`endif
    end

    assign drain     = (grant == GR_DRAIN);
    assign push      = bus.store_en && (!full || drain);
    assign bus.stall = !rst && ((grant != GR_FETCH) || (bus.load_en && (grant != GR_LOAD)));

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wb_idx[tail] <= s_idx;
                wb_dat[tail] <= bus.s_data;
                tail         <= tail + 1'b1;
            end
            if (drain) begin
                head <= head + 1'b1;
            end
            case ({push, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && drain) begin
            ram[wb_idx[head]] <= wb_dat[head];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.read_inst <= '0;
            bus.l_data    <= '0;
        end else begin
            case (grant)
                GR_LOAD:  bus.l_data    <= fwd_hit ? fwd_dat : ram[l_idx];
                GR_FETCH: bus.read_inst <= ram[pc_idx];
                default:  ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: fetch, store drain, load forwarding/hazard drain, same-cycle load+store, reset.
// Works with or without MEM_CTRL_FWD_EN; stall-cycle counts differ between the two builds.
module tb_mem_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

`ifdef MEM_CTRL_FWD_EN
    localparam int HAZ_CYC = 2;
`else
    localparam int HAZ_CYC = 3;
`endif

    mem_ctrl_if #(.W(32)) bus ();

    mem_ctrl #(.W(32), .ADDR_W(10), .WB_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        #4;
        chk(tag, {31'b0, bus.stall}, {31'b0, exp});
    endtask

    task automatic drive(input logic ld, input logic [31:0] la,
                         input logic st, input logic [31:0] sa, input logic [31:0] sd);
        bus.load_en  = ld;
        bus.l_addr   = la;
        bus.store_en = st;
        bus.s_addr   = sa;
        bus.s_data   = sd;
    endtask

    task automatic reset_cycle();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.pc = 32'h0;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();

        drive(1'b1, 32'h10, 1'b0, 32'h0, 32'h0);
        chk_stall("rst_stall_low", 1'b0);
        tick();
        chk("rst_read_inst", bus.read_inst, 32'h0);
        chk("rst_l_data", bus.l_data, 32'h0);
        chk("rst_count", 32'(dut.count), 32'd0);
        rst = 1'b0;

        // Fill RAM[4], RAM[5], RAM[0], RAM[1] through the buffer
        drive(1'b0, 32'h0, 1'b1, 32'h10, 32'h2402000A);
        chk_stall("st1_stall", 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h14, 32'hBBBB0005);
        chk_stall("st2_stall", 1'b0);
        tick();
        chk("full_count", 32'(dut.count), 32'd2);
        drive(1'b0, 32'h0, 1'b1, 32'h0, 32'h11111111);
        chk_stall("st3_drain_stall", 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h4, 32'h22222222);
        chk_stall("st4_drain_stall", 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h8, 32'h33333333);
        chk_stall("t3_drain_stall", 1'b1);
        tick();
        chk("t3_count_stays", 32'(dut.count), 32'd2);

        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        bus.pc = 32'h10;
        chk_stall("drain_to_one", 1'b1);
        tick();
        chk("drain_count", 32'(dut.count), 32'd1);

        // Test 1: fetch
        chk_stall("t1_fetch_stall", 1'b0);
        tick();
        chk("t1_read_inst", bus.read_inst, 32'h2402000A);

        bus.pc = 32'h0;
        drive(1'b0, 32'h0, 1'b1, 32'h10, 32'h99999999);
        chk_stall("fetch0_stall", 1'b0);
        tick();
        chk("t3_ram0_drained", bus.read_inst, 32'h11111111);
        chk("two_buffered", 32'(dut.count), 32'd2);

        // Test 6: reset with full buffer; drain write suppressed, stores dropped
        rst = 1'b1;
        drive(1'b1, 32'h10, 1'b0, 32'h0, 32'h0);
        chk_stall("t6_stall_in_rst", 1'b0);
        tick();
        chk("t6_read_inst", bus.read_inst, 32'h0);
        chk("t6_l_data", bus.l_data, 32'h0);
        chk("t6_count", 32'(dut.count), 32'd0);
        rst = 1'b0;
        chk_stall("t6_load_stall", 1'b1);
        tick();
        chk("t6_ram_kept", bus.l_data, 32'h2402000A);

        // Test 2: store then load same address
        drive(1'b0, 32'h0, 1'b1, 32'h20, 32'hDEADBEEF);
        chk_stall("t2_store_stall", 1'b0);
        tick();
        drive(1'b1, 32'h20, 1'b0, 32'h0, 32'h0);
`ifdef MEM_CTRL_FWD_EN
        chk_stall("t2_load_stall", 1'b1);
        tick();
`else
        chk_stall("t2_hazard_stall", 1'b1);
        tick();
        chk("t2_l_data_hold", bus.l_data, 32'h2402000A);
        chk_stall("t2_load_stall", 1'b1);
        tick();
`endif
        chk("t2_l_data", bus.l_data, 32'hDEADBEEF);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk_stall("t2_release", 1'b0);
        tick();
        reset_cycle();

        // Test 4: youngest entry wins
        drive(1'b0, 32'h0, 1'b1, 32'h30, 32'h1);
        chk_stall("t4_st1_stall", 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h30, 32'h2);
        chk_stall("t4_st2_stall", 1'b0);
        tick();
        drive(1'b1, 32'h30, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < HAZ_CYC; i++) begin
            chk_stall("t4_load_stall", 1'b1);
            tick();
        end
        chk("t4_l_data", bus.l_data, 32'h2);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        reset_cycle();

        // Test 5: same-cycle load and store to one index
        drive(1'b0, 32'h0, 1'b1, 32'h40, 32'h55);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h44, 32'h77);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk_stall("t5_preload_drain", 1'b1);
        tick();
        drive(1'b1, 32'h40, 1'b1, 32'h40, 32'h66);
        chk_stall("t5_ld_st_stall", 1'b1);
        tick();
        chk("t5_old_value", bus.l_data, 32'h55);
        drive(1'b1, 32'h40, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < HAZ_CYC; i++) begin
            chk_stall("t5_reload_stall", 1'b1);
            tick();
        end
        chk("t5_new_value", bus.l_data, 32'h66);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk_stall("t5_release", 1'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
